// File: rtl/control_sequencer.sv
// rtl/control_sequencer.sv - Moore microcode sequencer for the fetch/decode/execute datapath.
// Optional mul/div execution enabled by defining CU_MULDIV_EN.
module control_sequencer #(
    parameter int IR_W = 32,
    parameter int OPW  = 5,
    parameter int TO_W = 4
) (
    input  logic            Clock,
    input  logic            Reset,
    input  logic            Stop,
    input  logic [IR_W-1:0] ir,
    input  logic            CON_FF,
    input  logic            mem_ready,
    output logic [9:0]      en,
    output logic [6:0]      sel,
    output logic [2:0]      gr,
    output logic            MD_Read,
    output logic            Write,
    output logic            IncPC,
    output logic [OPW-1:0]  alu_op,
    output logic            run,
    output logic [1:0]      err,
    output logic [3:0]      state
);

`ifdef CU_MULDIV_EN
    localparam bit MULDIV_EN = 1'b1;
`else
    localparam bit MULDIV_EN = 1'b0;
`endif

    typedef enum logic [3:0] {
        S_RESET = 4'd0, S_F0 = 4'd1, S_F1 = 4'd2, S_F2 = 4'd3, S_T3 = 4'd4,
        S_T4 = 4'd5, S_T5 = 4'd6, S_T6 = 4'd7, S_T7 = 4'd8, S_HALT = 4'd9
    } state_t;

    localparam int EN_PC = 0, EN_IR = 1, EN_MAR = 2, EN_MDR = 3, EN_Y = 4;
    localparam int EN_Z = 5, EN_HI = 6, EN_LO = 7, EN_CON = 8, EN_R = 9;
    localparam int SEL_PC = 0, SEL_MDR = 1, SEL_ZLO = 2, SEL_ZHI = 3;
    localparam int SEL_C = 4, SEL_R = 5, SEL_BA = 6;
    localparam logic [2:0] GRA = 3'b100, GRB = 3'b010, GRC = 3'b001;
    localparam logic [OPW-1:0] ALU_ADD = OPW'(3);

    state_t          state_q, state_d;
    logic [TO_W-1:0] cnt_q, cnt_d, cnt_inc;
    logic [1:0]      err_q, err_d;
    logic            mem_wait, next_fetch;

    logic [OPW-1:0] op;
    logic is_ralu, is_ialu, is_ldi, is_ld, is_st, is_mi, is_br, is_md, is_nop, is_halt;
    logic unused_ir;

    assign op        = ir[IR_W-1:IR_W-OPW];
    assign unused_ir = ^ir[IR_W-OPW-1:0];
    assign is_ralu   = (op >= OPW'(3)) && (op <= OPW'(10));
    assign is_ialu   = (op >= OPW'(11)) && (op <= OPW'(13));
    assign is_ldi    = (op == OPW'(1));
    assign is_ld     = (op == OPW'(0));
    assign is_st     = (op == OPW'(2));
    assign is_mi     = is_ldi || is_ld || is_st;
    assign is_br     = (op == OPW'(18));
    assign is_md     = MULDIV_EN && ((op == OPW'(14)) || (op == OPW'(15)));
    assign is_nop    = (op == OPW'(24));
    assign is_halt   = (op == OPW'(25));
    assign cnt_inc   = cnt_q + TO_W'(1);

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state_q <= S_RESET;
            cnt_q   <= '0;
            err_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = '0;
        err_d      = err_q;
        en         = '0;
        sel        = '0;
        gr         = '0;
        MD_Read    = 1'b0;
        Write      = 1'b0;
        IncPC      = 1'b0;
        alu_op     = '0;
        mem_wait   = 1'b0;
        next_fetch = 1'b0;
        case (state_q)
            S_RESET: state_d = S_F0;
            S_F0: begin
                sel[SEL_PC] = 1'b1; en[EN_MAR] = 1'b1; en[EN_Z] = 1'b1; IncPC = 1'b1;
                state_d = S_F1;
            end
            S_F1: begin
                sel[SEL_ZLO] = 1'b1; en[EN_PC] = 1'b1; en[EN_MDR] = 1'b1; MD_Read = 1'b1;
                mem_wait = 1'b1;
                state_d  = S_F2;
            end
            S_F2: begin
                sel[SEL_MDR] = 1'b1; en[EN_IR] = 1'b1;
                if (is_ralu || is_ialu || is_mi || is_br || is_md) state_d = S_T3;
                else if (is_nop) next_fetch = 1'b1;
                else if (is_halt) state_d = S_HALT;
                else begin
                    err_d[0] = 1'b1;
                    state_d  = S_HALT;
                end
            end
            S_T3: begin
                state_d = S_T4;
                if (is_ralu || is_ialu) begin gr = GRB; sel[SEL_R] = 1'b1; en[EN_Y] = 1'b1; end
                else if (is_mi) begin gr = GRB; sel[SEL_BA] = 1'b1; en[EN_Y] = 1'b1; end
                else if (is_br) begin gr = GRA; sel[SEL_R] = 1'b1; en[EN_CON] = 1'b1; end
                else if (is_md) begin gr = GRA; sel[SEL_R] = 1'b1; en[EN_Y] = 1'b1; end
                else state_d = S_HALT;
            end
            S_T4: begin
                state_d = S_T5;
                if (is_ralu) begin gr = GRC; sel[SEL_R] = 1'b1; en[EN_Z] = 1'b1; alu_op = op; end
                else if (is_ialu) begin sel[SEL_C] = 1'b1; en[EN_Z] = 1'b1; alu_op = op; end
                else if (is_mi) begin sel[SEL_C] = 1'b1; en[EN_Z] = 1'b1; alu_op = ALU_ADD; end
                else if (is_br) begin sel[SEL_PC] = 1'b1; en[EN_Y] = 1'b1; end
                else if (is_md) begin gr = GRB; sel[SEL_R] = 1'b1; en[EN_Z] = 1'b1; alu_op = op; end
                else state_d = S_HALT;
            end
            S_T5: begin
                state_d = S_T6;
                if (is_ralu || is_ialu || is_ldi) begin
                    sel[SEL_ZLO] = 1'b1; gr = GRA; en[EN_R] = 1'b1; next_fetch = 1'b1;
                end
                else if (is_ld || is_st) begin sel[SEL_ZLO] = 1'b1; en[EN_MAR] = 1'b1; end
                else if (is_br) begin sel[SEL_C] = 1'b1; en[EN_Z] = 1'b1; alu_op = ALU_ADD; end
                else if (is_md) begin sel[SEL_ZLO] = 1'b1; en[EN_LO] = 1'b1; end
                else state_d = S_HALT;
            end
            S_T6: begin
                state_d = S_T7;
                if (is_ld) begin MD_Read = 1'b1; en[EN_MDR] = 1'b1; mem_wait = 1'b1; end
                else if (is_st) begin gr = GRA; sel[SEL_R] = 1'b1; en[EN_MDR] = 1'b1; end
                else if (is_br) begin
                    sel[SEL_ZLO] = 1'b1; en[EN_PC] = CON_FF; next_fetch = 1'b1;
                end
                else if (is_md) begin sel[SEL_ZHI] = 1'b1; en[EN_HI] = 1'b1; next_fetch = 1'b1; end
                else state_d = S_HALT;
            end
            S_T7: begin
                if (is_ld) begin
                    sel[SEL_MDR] = 1'b1; gr = GRA; en[EN_R] = 1'b1; next_fetch = 1'b1;
                end
                else if (is_st) begin Write = 1'b1; mem_wait = 1'b1; next_fetch = 1'b1; end
                else state_d = S_HALT;
            end
            S_HALT: state_d = S_HALT;
            default: state_d = S_HALT;
        endcase
        // Stop is only honoured at an instruction boundary.
        if (next_fetch) state_d = Stop ? S_HALT : S_F0;
        // A completing handshake beats the timeout in the same cycle.
        if (mem_wait && !mem_ready) begin
            if (&cnt_inc) begin
                err_d[1] = 1'b1;
                state_d  = S_HALT;
            end else begin
                cnt_d   = cnt_inc;
                state_d = state_q;
            end
        end
    end

    assign run   = (state_q != S_RESET) && (state_q != S_HALT);
    assign err   = err_q;
    assign state = state_q;

endmodule

// File: doc/control_sequencer.md
CONTROL_SEQUENCER -- requirements
Module: control_sequencer

Interface
REQ-001 Parameter IR_W, default 32: instruction register width; opcode is ir[IR_W-1:IR_W-OPW].
REQ-002 Parameter OPW, default 5: opcode width; alu_op width.
REQ-003 Parameter TO_W, default 4: memory-wait timeout counter width; timeout after 2^TO_W-1 wait cycles.
REQ-004 Clock  in  1  system clock, all state on rising edge.
REQ-005 Reset  in  1  asynchronous, active-high.
REQ-006 Stop  in  1  halt request, sampled at instruction boundary.
REQ-007 ir  in  IR_W  current instruction.
REQ-008 CON_FF  in  1  branch condition flop.
REQ-009 mem_ready  in  1  memory handshake: access complete this cycle.
REQ-010 en  out  10  register loads: 0 PCin, 1 IRin, 2 MARin, 3 MDRin, 4 Yin, 5 Zin, 6 HIin, 7 LOin, 8 CONin, 9 Rin.
REQ-011 sel  out  7  one-hot bus drivers: 0 PCout, 1 MDRout, 2 ZLowout, 3 ZHighout, 4 Cout, 5 Rout, 6 BAout.
REQ-012 gr  out  3  register-field selects {Gra, Grb, Grc}.
REQ-013 MD_Read, Write, IncPC  out  1 each  memory read-select, memory write strobe, ALU PC-increment.
REQ-014 alu_op  out  OPW  ALU operation code, 0 when unused.
REQ-015 run  out  1  high except in HALT and RESET.
REQ-016 err  out  2  sticky: bit0 illegal opcode, bit1 memory timeout.
REQ-017 state  out  4  encoded present state for debug.

Function
REQ-018 States: RESET, F0, F1, F2, T3..T7, HALT; all outputs are Moore functions of state, opcode and CON_FF; sel is at most one-hot.
REQ-019 RESET->F0 unconditionally; F0 -> HALT instead if Stop=1 at F0 entry evaluation (instruction boundary only; Stop mid-instruction is deferred).
REQ-020 F0: PCout, MARin, IncPC, Zin.  F1: ZLowout, PCin, MD_Read, MDRin; held until mem_ready.  F2: MDRout, IRin; then decode to T3.
REQ-021 Opcodes 00011-01010 (R-ALU): T3 Grb Rout Yin; T4 Grc Rout Zin alu_op=opcode; T5 ZLowout Gra Rin; ->F0.
REQ-022 Opcodes 01011-01101 (I-ALU): T3 Grb Rout Yin; T4 Cout Zin alu_op=opcode; T5 ZLowout Gra Rin; ->F0.
REQ-023 00001 ldi: T3 Grb BAout Yin; T4 Cout Zin alu_op=00011; T5 ZLowout Gra Rin; ->F0.
REQ-024 00000 ld: T3-T4 as ldi; T5 ZLowout MARin; T6 MD_Read MDRin, held until mem_ready; T7 MDRout Gra Rin; ->F0.
REQ-025 00010 st: T3-T5 as ld; T6 Gra Rout MDRin (MD_Read=0); T7 Write, held until mem_ready; ->F0.
REQ-026 10010 br: T3 Gra Rout CONin; T4 PCout Yin; T5 Cout Zin alu_op=00011; T6 ZLowout plus PCin only if CON_FF=1; ->F0.
REQ-027 11000 nop: F2->F0 directly.  11001 halt: F2->HALT.
REQ-028 Any other opcode: set err[0], ->HALT.
REQ-029 Wait states (F1, ld T6, st T7): timeout counter clears on state entry, increments each cycle mem_ready=0; reaching all-ones sets err[1], ->HALT, all strobes deasserted; mem_ready=1 on the same cycle wins.
REQ-030 HALT: all en, sel, gr, strobes 0, run=0; exit only by Reset.

Reset
REQ-031 Reset forces RESET immediately at any point, including mid-instruction or during a wait; all outputs 0, err=0, timeout counter=0.
REQ-032 First rising Clock after Reset deasserts enters F0.

Configuration
REQ-033 Macro CU_MULDIV_EN: when defined, opcodes 01110 mul / 01111 div execute T3 Gra Rout Yin; T4 Grb Rout Zin alu_op=opcode; T5 ZLowout LOin; T6 ZHighout HIin; ->F0.
REQ-034 Without CU_MULDIV_EN, 01110/01111 are illegal per REQ-028; HIin, LOin, ZHighout are tied 0.

Verification
REQ-035 Reset, ir=0x18A00000 (add), mem_ready=1 -> F0,F1,F2,T3,T4,T5,F0 in 6 cycles; T4 shows alu_op=00011, gr=001, en[5]=1.
REQ-036 ld with mem_ready low 3 cycles in T6 -> T6 held exactly 3 extra cycles, MD_Read=1, en[3]=1 throughout; T7 shows sel[1], en[9].
REQ-037 br, CON_FF=0 then CON_FF=1 -> T6 en[0]=0 then en[0]=1.
REQ-038 Stop raised during add T4 -> add completes, next F0 evaluation goes HALT, run=0; opcode 11111 -> err=01, HALT.
REQ-039 mem_ready held 0 in F1 with TO_W=4 -> after 15 wait cycles err=10, HALT; Reset asserted mid-wait -> state=RESET same cycle, err=00.
REQ-040 mul with and without CU_MULDIV_EN -> 4-step sequence with en[7] then en[6]; versus err=01 and HALT.
